// File: rtl/single_port_ram_pkg.sv
// rtl/single_port_ram_pkg.sv - default geometry of the scratch RAM
// Blocks that size buffers against this RAM import these instead of repeating numbers.
package single_port_ram_pkg;
    localparam int SPR_DATA_WIDTH = 8;
    localparam int SPR_ADDR_WIDTH = 4;
endpackage

// File: rtl/single_port_ram.sv
// rtl/single_port_ram.sv - flop-based single-port RAM, write-first, registered read data
// Port order matches legacy positional instantiations (clk, we, addr, din, dout).
module single_port_ram
    import single_port_ram_pkg::*;
#(
    parameter int DATA_WIDTH = SPR_DATA_WIDTH,
    parameter int ADDR_WIDTH = SPR_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic                  rst_n
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] dout_q;
    logic [DATA_WIDTH-1:0] dout_d;

    // Write-first: a write cycle forwards din rather than the stale word.
    always_comb begin
        dout_d = mem_q[addr];
        if (we) begin
            dout_d = din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            dout_q <= '0;
        end else begin
            if (we) begin
                mem_q[addr] <= din;
            end
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_single_port_ram.sv
// tb/tb_single_port_ram.sv - scoreboard bench for single_port_ram
module tb_single_port_ram;

    logic       clk;
    logic       rst_n;
    logic       we;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] dout;

    logic [7:0] model [16];
    logic [7:0] exp_q [$];
    int         n_cmp;
    int         n_err;

    single_port_ram dut (
        .clk  (clk),
        .we   (we),
        .addr (addr),
        .din  (din),
        .dout (dout),
        .rst_n(rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic w, input logic [3:0] a, input logic [7:0] d);
        logic [7:0] e;
        @(negedge clk);
        we   = w;
        addr = a;
        din  = d;
        if (w) begin
            model[a] = d;
            exp_q.push_back(d);
        end else begin
            exp_q.push_back(model[a]);
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq($sformatf("%s a=%0d", tag, a), dout, e);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clear_model();
        rst_n = 1'b0;
        we    = 1'b0;
        addr  = 4'd0;
        din   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_dout", dout, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) do_op("reset_read", 1'b0, 4'(i), 8'h00);

        do_op("wr0", 1'b1, 4'd0, 8'd15);
        do_op("wr1", 1'b1, 4'd1, 8'd25);
        do_op("wr2", 1'b1, 4'd2, 8'd35);
        do_op("rd", 1'b0, 4'd0, 8'h00);
        do_op("rd", 1'b0, 4'd1, 8'h00);
        do_op("rd", 1'b0, 4'd2, 8'h00);

        do_op("wfirst_wr", 1'b1, 4'd5, 8'hA5);
        do_op("wfirst_rd", 1'b0, 4'd5, 8'h00);

        // dout must not follow addr between edges
        #2;
        addr = 4'd0;
        #1;
        check_eq("hold_no_comb", dout, 8'hA5);

        for (int i = 0; i < 16; i++) do_op("sweep_wr", 1'b1, 4'(i), 8'hF0 ^ 8'(i));
        for (int i = 15; i >= 0; i--) do_op("sweep_rd", 1'b0, 4'(i), 8'h00);

        // async reset pulse of 3 ns between edges
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_dout", dout, 8'h00);
        #2;
        rst_n = 1'b1;
        clear_model();
        do_op("post_rst_rd", 1'b0, 4'd15, 8'h00);
        do_op("post_rst_rd", 1'b0, 4'd0, 8'h00);

        do_op("ow_nb_wr", 1'b1, 4'd2, 8'h5A);
        do_op("ow_nb_wr", 1'b1, 4'd4, 8'hC3);
        do_op("ow_wr1", 1'b1, 4'd3, 8'h11);
        do_op("ow_wr2", 1'b1, 4'd3, 8'h22);
        do_op("ow_rd", 1'b0, 4'd3, 8'h00);
        do_op("ow_nb_rd", 1'b0, 4'd2, 8'h00);
        do_op("ow_nb_rd", 1'b0, 4'd4, 8'h00);

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
